servo_slew_scheduler: RTL and testbench

// Sequences the X/Y servo angle commands fed to the PWM width math. It latches SPI

---
 rtl/servo_slew_scheduler.sv | 133 +++++++++++++
 tb/tb_servo_slew_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_slew_scheduler.sv
// servo_slew_scheduler
// Moves the X/Y servo angle commands toward the latched SPI targets by at most
// MAX_STEP per axis, once every STEP_DIV PWM frames, so that PWM widths only
// change on frame boundaries and the mechanics never see a jerk.
// Optional build macro LASER_BLANK_EN: darkens the laser while the servos slew.
// Without it the laser enable is tied high.
module servo_slew_scheduler #(
    parameter int MAX_STEP  = 4,
    parameter int STEP_DIV  = 1,
    parameter int ANGLE_MIN = 0,
    parameter int ANGLE_MAX = 255,
    parameter int CENTER    = 128
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       tgt_valid,
    input  logic [7:0] tgt_x,
    input  logic [7:0] tgt_y,
    output logic [7:0] angle_x,
    output logic [7:0] angle_y,
    output logic       moving,
    output logic       step_pulse,
    output logic       laser_on
);

    localparam logic [7:0] STEP8    = 8'(MAX_STEP);
    localparam logic [7:0] MIN8     = 8'(ANGLE_MIN);
    localparam logic [7:0] MAX8     = 8'(ANGLE_MAX);
    localparam logic [7:0] CENTER8  = 8'(CENTER);
    localparam logic [7:0] DIV_LAST = 8'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STEP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] tgt_x_reg;
    logic [7:0] tgt_y_reg;
    logic [7:0] div_cnt;
    logic [7:0] nxt_x;
    logic [7:0] nxt_y;
    logic       step_due;
    logic       at_target;
    logic       step_moves;

    // Targets are limited to the mechanical range as they are captured, which
    // also bounds every slew result, so the step arithmetic can never wrap.
    function automatic logic [7:0] clamp_angle(input logic [7:0] v);
        if (int'(v) < ANGLE_MIN) return MIN8;
        if (int'(v) > ANGLE_MAX) return MAX8;
        return v;
    endfunction

    // One bounded move from cur toward tgt; lands exactly on tgt when close.
    function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] mag;
        mag = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
        if (mag <= STEP8) return tgt;
        return (tgt > cur) ? (cur + STEP8) : (cur - STEP8);
    endfunction

    assign step_due   = frame_tick && (div_cnt == DIV_LAST);
    assign at_target  = (angle_x == tgt_x_reg) && (angle_y == tgt_y_reg);
    assign nxt_x      = slew(angle_x, tgt_x_reg);
    assign nxt_y      = slew(angle_y, tgt_y_reg);
    assign step_moves = (nxt_x != angle_x) || (nxt_y != angle_y);
    assign moving     = (state != S_IDLE);

`ifdef LASER_BLANK_EN
    assign laser_on = ~moving;
`else
    assign laser_on = 1'b1;
`endif

    // Next-state decode for the slew sequencer.
    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE: if (!at_target) state_nxt = S_WAIT;
            // A retarget back onto the current angles cancels the pending step.
            S_WAIT: begin
                if (at_target)     state_nxt = S_IDLE;
                else if (step_due) state_nxt = S_STEP;
            end
            S_STEP: state_nxt = ((nxt_x == tgt_x_reg) && (nxt_y == tgt_y_reg)) ? S_IDLE : S_WAIT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register, commanded angles and step strobe; angles move only in STEP.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            angle_x    <= CENTER8;
            angle_y    <= CENTER8;
            step_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state      <= state_nxt;
            step_pulse <= (state == S_STEP) && step_moves;
            if (state == S_STEP) begin
                angle_x <= nxt_x;
                angle_y <= nxt_y;
            end
        end
    end

    // Target capture; last valid wins, always accepted.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            tgt_x_reg <= CENTER8;
            tgt_y_reg <= CENTER8;
        end else if (tgt_valid) begin
            tgt_x_reg <= clamp_angle(tgt_x);
            tgt_y_reg <= clamp_angle(tgt_y);
        end
    end

    // Frame divider runs in every state so the step phase stays frame-locked.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (frame_tick) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : (div_cnt + 8'd1);
        end
    end

endmodule

// File: tb/tb_servo_slew_scheduler.sv
// tb_servo_slew_scheduler
// Three instances share one stimulus stream: default build, STEP_DIV=3, and a
// clamped range 20..230. Directed scenarios use hand-derived values; the random
// scenario is compared against a frame-level behavioural model.
module tb_servo_slew_scheduler;

    logic       CLK;
    logic       rst;
    logic       frame_tick;
    logic       tgt_valid;
    logic [7:0] tgt_x;
    logic [7:0] tgt_y;
    logic [7:0] ax [3];
    logic [7:0] ay [3];
    logic       mv [3];
    logic       sp [3];
    logic       lz [3];

    int total = 0;
    int bad   = 0;

`ifdef LASER_BLANK_EN
    localparam logic LASER_WHILE_MOVING = 1'b0;
`else
    localparam logic LASER_WHILE_MOVING = 1'b1;
`endif

    // Per-instance configuration as seen by the model.
    int p_step [3] = '{4, 4, 4};
    int p_div  [3] = '{1, 3, 1};
    int p_min  [3] = '{0, 0, 20};
    int p_max  [3] = '{255, 255, 230};

    // Model state: targets, angles, tick count and one scheduled step.
    int   m_tx [3];
    int   m_ty [3];
    int   m_ax [3];
    int   m_ay [3];
    int   m_ticks [3];
    bit   m_pend [3];
    int   m_px [3];
    int   m_py [3];
    bit   m_pulse [3];

    servo_slew_scheduler u_dut0 (
        .CLK(CLK), .rst(rst), .frame_tick(frame_tick), .tgt_valid(tgt_valid),
        .tgt_x(tgt_x), .tgt_y(tgt_y), .angle_x(ax[0]), .angle_y(ay[0]),
        .moving(mv[0]), .step_pulse(sp[0]), .laser_on(lz[0])
    );

    servo_slew_scheduler #(.STEP_DIV(3)) u_dut1 (
        .CLK(CLK), .rst(rst), .frame_tick(frame_tick), .tgt_valid(tgt_valid),
        .tgt_x(tgt_x), .tgt_y(tgt_y), .angle_x(ax[1]), .angle_y(ay[1]),
        .moving(mv[1]), .step_pulse(sp[1]), .laser_on(lz[1])
    );

    servo_slew_scheduler #(.ANGLE_MIN(20), .ANGLE_MAX(230)) u_dut2 (
        .CLK(CLK), .rst(rst), .frame_tick(frame_tick), .tgt_valid(tgt_valid),
        .tgt_x(tgt_x), .tgt_y(tgt_y), .angle_x(ax[2]), .angle_y(ay[2]),
        .moving(mv[2]), .step_pulse(sp[2]), .laser_on(lz[2])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int clamp_m(input int i, input int v);
        if (v < p_min[i]) return p_min[i];
        if (v > p_max[i]) return p_max[i];
        return v;
    endfunction

    function automatic int approach(input int cur, input int tgt, input int stp);
        int d;
        d = tgt - cur;
        if (d > stp)  return cur + stp;
        if (d < -stp) return cur - stp;
        return tgt;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_tx[i] = 128; m_ty[i] = 128; m_ax[i] = 128; m_ay[i] = 128;
            m_ticks[i] = 0; m_pend[i] = 1'b0; m_pulse[i] = 1'b0;
            m_px[i] = 128; m_py[i] = 128;
        end
    endtask

    // Drive one cycle of inputs, let the clock edge pass, advance the model.
    // A step earned on a qualifying tick becomes visible one edge later.
    task automatic drive_cycle(input logic fr, input logic tv, input logic [7:0] tx, input logic [7:0] ty);
        int nx, ny;
        frame_tick = fr; tgt_valid = tv; tgt_x = tx; tgt_y = ty;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            m_pulse[i] = 1'b0;
            if (m_pend[i]) begin
                m_ax[i] = m_px[i]; m_ay[i] = m_py[i];
                m_pend[i] = 1'b0; m_pulse[i] = 1'b1;
            end
            if (tv) begin
                m_tx[i] = clamp_m(i, int'(tx));
                m_ty[i] = clamp_m(i, int'(ty));
            end
            if (fr) begin
                m_ticks[i]++;
                if (m_ticks[i] % p_div[i] == 0) begin
                    nx = approach(m_ax[i], m_tx[i], p_step[i]);
                    ny = approach(m_ay[i], m_ty[i], p_step[i]);
                    if (nx != m_ax[i] || ny != m_ay[i]) begin
                        m_pend[i] = 1'b1; m_px[i] = nx; m_py[i] = ny;
                    end
                end
            end
        end
        frame_tick = 1'b0; tgt_valid = 1'b0;
    endtask

    task automatic do_reset();
        frame_tick = 1'b0; tgt_valid = 1'b0; tgt_x = 8'd0; tgt_y = 8'd0;
        rst = 1'b1;
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        rst = 1'b0;
    endtask

    // Plain frames: three idle cycles then one frame_tick.
    task automatic run_frames(input int n);
        for (int f = 0; f < n; f++) begin
            for (int c = 0; c < 4; c++) drive_cycle(c == 3, 1'b0, 8'd0, 8'd0);
        end
    endtask

    task automatic test_reset();
        bit seen;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            total++; if (ax[i] !== 8'd128) begin bad++; $display("FAIL reset_angle_x[%0d]: got %0d expected 128", i, ax[i]); end
            total++; if (ay[i] !== 8'd128) begin bad++; $display("FAIL reset_angle_y[%0d]: got %0d expected 128", i, ay[i]); end
            total++; if (mv[i] !== 1'b0) begin bad++; $display("FAIL reset_moving[%0d]: got %b expected 0", i, mv[i]); end
            total++; if (sp[i] !== 1'b0) begin bad++; $display("FAIL reset_step_pulse[%0d]: got %b expected 0", i, sp[i]); end
            total++; if (lz[i] !== 1'b1) begin bad++; $display("FAIL reset_laser[%0d]: got %b expected 1", i, lz[i]); end
        end
        // Start a slew, then hit reset while a step pulse is being shown.
        drive_cycle(1'b0, 1'b1, 8'd200, 8'd60);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            drive_cycle((c % 4) == 3, 1'b0, 8'd0, 8'd0);
            if (sp[0] === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL reset_wait_first_step: got none expected a step_pulse within 40 cycles"); end
        rst = 1'b1;
        #1;
        total++; if (ax[0] !== 8'd128) begin bad++; $display("FAIL midreset_angle_x: got %0d expected 128", ax[0]); end
        total++; if (ay[0] !== 8'd128) begin bad++; $display("FAIL midreset_angle_y: got %0d expected 128", ay[0]); end
        total++; if (mv[0] !== 1'b0) begin bad++; $display("FAIL midreset_moving: got %b expected 0", mv[0]); end
        total++; if (sp[0] !== 1'b0) begin bad++; $display("FAIL midreset_step_pulse: got %b expected 0", sp[0]); end
        total++; if (lz[0] !== 1'b1) begin bad++; $display("FAIL midreset_laser: got %b expected 1", lz[0]); end
        model_reset();
        @(posedge CLK);
        #1;
        rst = 1'b0;
        // The abandoned target must not resume after reset.
        run_frames(3);
        total++; if (ax[0] !== 8'd128 || mv[0] !== 1'b0) begin bad++; $display("FAIL reset_abandons_target: got angle_x=%0d moving=%b expected 128/0", ax[0], mv[0]); end
    endtask

    task automatic test_slew_up();
        int exp_x, pulses;
        do_reset();
        drive_cycle(1'b0, 1'b1, 8'd200, 8'd128);
        drive_cycle(1'b0, 1'b0, 8'd0, 8'd0);
        total++; if (mv[0] !== 1'b1) begin bad++; $display("FAIL slew_moving_after_capture: got %b expected 1", mv[0]); end
        total++; if (lz[0] !== LASER_WHILE_MOVING) begin bad++; $display("FAIL slew_laser_moving: got %b expected %b", lz[0], LASER_WHILE_MOVING); end
        exp_x = 128; pulses = 0;
        for (int f = 0; f < 24; f++) begin
            for (int c = 0; c < 5; c++) begin
                drive_cycle(c == 4, 1'b0, 8'd0, 8'd0);
                if (sp[0] === 1'b1) begin
                    pulses++;
                    exp_x = (200 - exp_x <= 4) ? 200 : exp_x + 4;
                end
                total++; if (ax[0] !== 8'(exp_x)) begin bad++; $display("FAIL slew_angle_x: got %0d expected %0d", ax[0], exp_x); end
                total++; if (ay[0] !== 8'd128) begin bad++; $display("FAIL slew_angle_y: got %0d expected 128", ay[0]); end
            end
        end
        total++; if (pulses != 18) begin bad++; $display("FAIL slew_pulse_count: got %0d expected 18", pulses); end
        total++; if (ax[0] !== 8'd200) begin bad++; $display("FAIL slew_final_x: got %0d expected 200", ax[0]); end
        total++; if (mv[0] !== 1'b0) begin bad++; $display("FAIL slew_final_moving: got %b expected 0", mv[0]); end
        total++; if (lz[0] !== 1'b1) begin bad++; $display("FAIL slew_final_laser: got %b expected 1", lz[0]); end
        // Retargeting to the present angles must not cause any activity.
        drive_cycle(1'b0, 1'b1, 8'd200, 8'd128);
        for (int c = 0; c < 12; c++) begin
            drive_cycle((c % 4) == 3, 1'b0, 8'd0, 8'd0);
            total++; if (sp[0] !== 1'b0 || mv[0] !== 1'b0) begin bad++; $display("FAIL same_target_quiet: got step=%b moving=%b expected 0/0", sp[0], mv[0]); end
        end
    endtask

    task automatic test_step_div();
        do_reset();
        drive_cycle(1'b0, 1'b1, 8'd130, 8'd128);
        for (int t = 1; t <= 3; t++) begin
            repeat (3) drive_cycle(1'b0, 1'b0, 8'd0, 8'd0);
            drive_cycle(1'b1, 1'b0, 8'd0, 8'd0);
            total++; if (ax[1] !== 8'd128) begin bad++; $display("FAIL div_before_step tick%0d: got %0d expected 128", t, ax[1]); end
        end
        drive_cycle(1'b0, 1'b0, 8'd0, 8'd0);
        total++; if (ax[1] !== 8'd130) begin bad++; $display("FAIL div_step_x: got %0d expected 130", ax[1]); end
        total++; if (sp[1] !== 1'b1) begin bad++; $display("FAIL div_step_pulse: got %b expected 1", sp[1]); end
        total++; if (mv[1] !== 1'b0) begin bad++; $display("FAIL div_moving_done: got %b expected 0", mv[1]); end
        drive_cycle(1'b0, 1'b0, 8'd0, 8'd0);
        total++; if (sp[1] !== 1'b0) begin bad++; $display("FAIL div_pulse_width: got %b expected 0", sp[1]); end
        total++; if (ax[0] !== 8'd130) begin bad++; $display("FAIL div1_step_x: got %0d expected 130", ax[0]); end
    endtask

    task automatic test_clamp();
        do_reset();
        drive_cycle(1'b0, 1'b1, 8'd5, 8'd250);
        run_frames(36);
        repeat (3) drive_cycle(1'b0, 1'b0, 8'd0, 8'd0);
        total++; if (ax[2] !== 8'd20) begin bad++; $display("FAIL clamp_x: got %0d expected 20", ax[2]); end
        total++; if (ay[2] !== 8'd230) begin bad++; $display("FAIL clamp_y: got %0d expected 230", ay[2]); end
        total++; if (mv[2] !== 1'b0) begin bad++; $display("FAIL clamp_moving: got %b expected 0", mv[2]); end
        total++; if (ax[0] !== 8'd5) begin bad++; $display("FAIL noclamp_x: got %0d expected 5", ax[0]); end
        total++; if (ay[0] !== 8'd250) begin bad++; $display("FAIL noclamp_y: got %0d expected 250", ay[0]); end
    endtask

    task automatic test_retarget();
        int exp_x, pulses;
        do_reset();
        drive_cycle(1'b0, 1'b1, 8'd150, 8'd128);
        run_frames(8);
        repeat (2) drive_cycle(1'b0, 1'b0, 8'd0, 8'd0);
        total++; if (ax[0] !== 8'd150) begin bad++; $display("FAIL retarget_start: got %0d expected 150", ax[0]); end
        drive_cycle(1'b0, 1'b1, 8'd200, 8'd128);
        repeat (3) drive_cycle(1'b0, 1'b0, 8'd0, 8'd0);
        drive_cycle(1'b1, 1'b0, 8'd0, 8'd0);
        // This cycle is the STEP cycle: the new target must not affect it.
        drive_cycle(1'b0, 1'b1, 8'd100, 8'd128);
        total++; if (ax[0] !== 8'd154) begin bad++; $display("FAIL retarget_first_step: got %0d expected 154", ax[0]); end
        total++; if (sp[0] !== 1'b1) begin bad++; $display("FAIL retarget_first_pulse: got %b expected 1", sp[0]); end
        exp_x = 154; pulses = 0;
        for (int f = 0; f < 18; f++) begin
            for (int c = 0; c < 5; c++) begin
                drive_cycle(c == 4, 1'b0, 8'd0, 8'd0);
                if (sp[0] === 1'b1) begin
                    pulses++;
                    exp_x = (exp_x - 100 <= 4) ? 100 : exp_x - 4;
                end
                total++; if (ax[0] !== 8'(exp_x)) begin bad++; $display("FAIL retarget_down_x: got %0d expected %0d", ax[0], exp_x); end
            end
        end
        total++; if (pulses != 14) begin bad++; $display("FAIL retarget_pulse_count: got %0d expected 14", pulses); end
        total++; if (ax[0] !== 8'd100) begin bad++; $display("FAIL retarget_final_x: got %0d expected 100", ax[0]); end
    endtask

    // Random targets and frame spacing, checked cycle by cycle against the model.
    // Targets are never issued in the last three cycles before a frame_tick,
    // so every tick sees a settled decision on whether motion is pending.
    task automatic test_random();
        int gap, sel, vx, vy;
        logic tv;
        do_reset();
        for (int f = 0; f < 80; f++) begin
            gap = int'($urandom_range(4, 9));
            for (int c = 0; c < gap; c++) begin
                tv = (c < gap - 3) && ($urandom_range(0, 3) == 0);
                sel = int'($urandom_range(0, 3));
                if (sel == 0) begin
                    vx = m_ax[0]; vy = m_ay[0];
                end else if (sel == 1) begin
                    vx = m_ax[0] + int'($urandom_range(0, 20)) - 10;
                    vy = m_ay[0] + int'($urandom_range(0, 20)) - 10;
                end else begin
                    vx = int'($urandom_range(0, 255));
                    vy = int'($urandom_range(0, 255));
                end
                vx = (vx < 0) ? 0 : (vx > 255) ? 255 : vx;
                vy = (vy < 0) ? 0 : (vy > 255) ? 255 : vy;
                drive_cycle(c == gap - 1, tv, 8'(vx), 8'(vy));
                for (int i = 0; i < 3; i++) begin
                    total++; if (ax[i] !== 8'(m_ax[i])) begin bad++; $display("FAIL rand_angle_x[%0d]: got %0d expected %0d", i, ax[i], m_ax[i]); end
                    total++; if (ay[i] !== 8'(m_ay[i])) begin bad++; $display("FAIL rand_angle_y[%0d]: got %0d expected %0d", i, ay[i], m_ay[i]); end
                    total++; if (sp[i] !== m_pulse[i]) begin bad++; $display("FAIL rand_step_pulse[%0d]: got %b expected %b", i, sp[i], m_pulse[i]); end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        frame_tick = 1'b0; tgt_valid = 1'b0; tgt_x = 8'd0; tgt_y = 8'd0;
        model_reset();
        test_reset();
        test_slew_up();
        test_step_div();
        test_clamp();
        test_retarget();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
